// File: rtl/msix_vector_fetch_if.sv
// Bundle of request, table-BRAM port B, message and pending-report signals
// around the MSI-X vector fetch block. master = fetch block, slave = its surroundings.
`timescale 1ns/1ps
interface msix_vector_fetch_if #(
  parameter int ADDR = 10
);
  logic            req_valid;
  logic [ADDR-3:0] req_vec;
  logic            req_ready;
  logic            fn_mask;
  logic [ADDR-1:0] mem_addr;
  logic            mem_wr;
  logic [31:0]     mem_din;
  logic [31:0]     mem_dout;
  logic            msg_valid;
  logic [63:0]     msg_addr;
  logic [31:0]     msg_data;
  logic            msg_ready;
  logic            pend_valid;
  logic [ADDR-3:0] pend_vec;

  modport master (
    input  req_valid, req_vec, fn_mask, mem_dout, msg_ready,
    output req_ready, mem_addr, mem_wr, mem_din,
           msg_valid, msg_addr, msg_data, pend_valid, pend_vec
  );

  modport slave (
    output req_valid, req_vec, fn_mask, mem_dout, msg_ready,
    input  req_ready, mem_addr, mem_wr, mem_din,
           msg_valid, msg_addr, msg_data, pend_valid, pend_vec
  );
endinterface

// File: rtl/msix_vector_fetch.sv
// Fetches one 4-word MSI-X table entry over BRAM port B and either emits the
// message or reports the vector as pending when it is masked.
`timescale 1ns/1ps
module msix_vector_fetch #(
  parameter int ADDR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  msix_vector_fetch_if.master   bus
);
  localparam int VW = ADDR - 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F1   = 3'd1;
  localparam logic [2:0] S_F2   = 3'd2;
  localparam logic [2:0] S_F3   = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_SEND = 3'd5;
  localparam logic [2:0] S_PEND = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [31:2]     addr_lo_q, addr_lo_d;
  logic [31:0]     addr_hi_q, addr_hi_d;
  logic [31:0]     data_q, data_d;
  logic            accept;

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    mem_addr_d = mem_addr_q;
    addr_lo_d  = addr_lo_q;
    addr_hi_d  = addr_hi_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          vec_d      = bus.req_vec;
          mem_addr_d = {bus.req_vec, 2'b01};
          state_d    = S_F1;
        end
      end
      // Each fetch state captures the word addressed one cycle earlier.
      S_F1: begin
        addr_lo_d  = bus.mem_dout[31:2];
        mem_addr_d = {vec_q, 2'b10};
        state_d    = S_F2;
      end
      S_F2: begin
        addr_hi_d  = bus.mem_dout;
        mem_addr_d = {vec_q, 2'b11};
        state_d    = S_F3;
      end
      S_F3: begin
        data_d  = bus.mem_dout;
        state_d = S_CHK;
      end
      S_CHK: begin
        state_d = (bus.fn_mask | bus.mem_dout[0]) ? S_PEND : S_SEND;
      end
      S_SEND: begin
        if (bus.msg_ready) begin
          state_d = S_IDLE;
        end
      end
      S_PEND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      mem_addr_q <= '0;
      addr_lo_q  <= '0;
      addr_hi_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      mem_addr_q <= mem_addr_d;
      addr_lo_q  <= addr_lo_d;
      addr_hi_q  <= addr_hi_d;
      data_q     <= data_d;
    end
  end

  // Word 0 is addressed in the accept cycle itself, hence the bypass around mem_addr_q.
  assign bus.mem_addr   = (accept && !rst) ? {bus.req_vec, 2'b00} : mem_addr_q;
  assign bus.mem_wr     = 1'b0;
  assign bus.mem_din    = '0;
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.msg_valid  = (state_q == S_SEND);
  assign bus.msg_addr   = {addr_hi_q, addr_lo_q, 2'b00};
  assign bus.msg_data   = data_q;
  assign bus.pend_valid = (state_q == S_PEND);
  assign bus.pend_vec   = vec_q;
endmodule
